// File: rtl/neuron_pkg.sv
// Shared types and default widths for the neuron datapath blocks
// (feeder, accumulator, activation).
package neuron_pkg;

   localparam int NEURON_XW = 10;
   localparam int NEURON_WW = 10;
   localparam int NEURON_DW = 20;
   localparam int NEURON_BW = 8;
   localparam int NEURON_SW = 22;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CLR    = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } feeder_state_t;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/neuron_feeder_if.sv
// Host-side operand write port and pass handshake of the neuron feeder.
interface neuron_feeder_if #(
   parameter int N_IN = 8,
   parameter int XW   = neuron_pkg::NEURON_XW,
   parameter int WW   = neuron_pkg::NEURON_WW
);
   localparam int AW = $clog2(N_IN);
   localparam int OW = neuron_pkg::max_w(XW, WW);

   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [OW-1:0] wr_data;
   logic          start;
   logic          busy;
   logic          done;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  busy, done
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output busy, done
   );
endinterface

// File: rtl/acc.sv
// Neuron accumulator: active-high clear loads the bias, otherwise sums din.
module acc
   import neuron_pkg::*;
#(
   parameter int b  = 11,
   parameter int DW = NEURON_DW,
   parameter int SW = NEURON_SW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] din,
   output logic signed [SW-1:0] dout
);

   localparam logic signed [SW-1:0] BIAS = SW'(b);

   always_ff @(posedge clk) begin
      if (rst) dout <= BIAS;
      else     dout <= dout + SW'(din);
   end

endmodule

// File: rtl/neuron_opmem.sv
// Dual-bank operand register file: bank 0 holds inputs, bank 1 weights.
// One write port, one combinational read port shared by both banks.
module neuron_opmem #(
   parameter int N_IN = 8,
   parameter int XW   = 10,
   parameter int WW   = 10,
   parameter int OW   = 10,
   parameter int AW   = $clog2(N_IN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic                 sel,
   input  logic [AW-1:0]        waddr,
   input  logic [OW-1:0]        wdata,
   input  logic [AW-1:0]        raddr,
   output logic signed [XW-1:0] x,
   output logic signed [WW-1:0] w
);

   logic signed [XW-1:0] xmem [N_IN];
   logic signed [WW-1:0] wmem [N_IN];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < N_IN; k++) begin
            xmem[k] <= '0;
            wmem[k] <= '0;
         end
      end else if (we) begin
         if (!sel) xmem[waddr] <= wdata[XW-1:0];
         else      wmem[waddr] <= wdata[WW-1:0];
      end
   end

   assign x = xmem[raddr];
   assign w = wmem[raddr];

endmodule

// File: rtl/neuron_feeder.sv
// Operand sequencer: clears the accumulator, streams x[i]*w[i] one per cycle,
// then pulses done once the accumulator holds bias + sum.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | din=0, operand writes accepted, waiting for start
//   ST_CLR    | acc_rst=1 for one cycle, operand 0 read
//   ST_STREAM | N_IN cycles of registered products on din
//   ST_DONE   | din=0, done=1 for one cycle, then back to idle
module neuron_feeder
   import neuron_pkg::*;
#(
   parameter int N_IN = 8,
   parameter int XW   = NEURON_XW,
   parameter int WW   = NEURON_WW,
   parameter int DW   = NEURON_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   neuron_feeder_if.slave       host,
   output logic                 acc_rst,
   output logic signed [DW-1:0] din,
   output logic                 din_valid
);

   localparam int AW = $clog2(N_IN);
   localparam int IW = AW + 1;
   localparam int OW = max_w(XW, WW);
   localparam int PW = XW + WW;
   localparam logic [IW-1:0] LAST = IW'(N_IN);

   feeder_state_t        state;
   logic [IW-1:0]        idx;
   logic signed [XW-1:0] x;
   logic signed [WW-1:0] w;
   logic signed [PW-1:0] prod;

   neuron_opmem #(
      .N_IN (N_IN),
      .XW   (XW),
      .WW   (WW),
      .OW   (OW),
      .AW   (AW)
   ) u_opmem (
      .clk   (clk),
      .rst   (rst),
      .we    (host.wr_en && (state == ST_IDLE)),
      .sel   (host.wr_sel),
      .waddr (host.wr_addr),
      .wdata (host.wr_data),
      .raddr (idx[AW-1:0]),
      .x     (x),
      .w     (w)
   );

   assign prod = x * w;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         din       <= '0;
         din_valid <= 1'b0;
         acc_rst   <= 1'b0;
         host.busy <= 1'b0;
         host.done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               din       <= '0;
               din_valid <= 1'b0;
               host.done <= 1'b0;
               acc_rst   <= 1'b0;
               if (host.start) begin
                  state     <= ST_CLR;
                  acc_rst   <= 1'b1;
                  host.busy <= 1'b1;
                  idx       <= '0;
               end
            end
            ST_CLR: begin
               acc_rst   <= 1'b0;
               din       <= DW'(prod);
               din_valid <= 1'b1;
               idx       <= idx + IW'(1);
               state     <= ST_STREAM;
            end
            ST_STREAM: begin
               // idx runs one ahead of the product on din
               if (idx == LAST) begin
                  din       <= '0;
                  din_valid <= 1'b0;
                  host.done <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  din <= DW'(prod);
                  idx <= idx + IW'(1);
               end
            end
            ST_DONE: begin
               host.done <= 1'b0;
               host.busy <= 1'b0;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder driving acc (b=11), checked against an array model
// of the operand banks and the dot-product timing.
module tb_neuron_feeder;
   localparam int N    = 8;
   localparam int BIAS = 11;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic acc_rst;
   logic signed [19:0] din;
   logic din_valid;
   logic signed [21:0] dout;

   neuron_feeder_if #(.N_IN(N), .XW(10), .WW(10)) hif ();

   neuron_feeder #(.N_IN(N), .XW(10), .WW(10), .DW(20)) dut (
      .clk       (clk),
      .rst       (rst),
      .host      (hif),
      .acc_rst   (acc_rst),
      .din       (din),
      .din_valid (din_valid)
   );

   acc #(.b(BIAS), .DW(20), .SW(22)) u_acc (
      .clk  (clk),
      .rst  (acc_rst),
      .din  (din),
      .dout (dout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int xm [N];
   int wm [N];

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int sx10(input int v);
      int t;
      t = v & 1023;
      return (t >= 512) ? t - 1024 : t;
   endfunction

   task automatic mwrite(input bit sel, input int addr, input int val);
      hif.wr_en   = 1'b1;
      hif.wr_sel  = sel;
      hif.wr_addr = 3'(addr);
      hif.wr_data = 10'(val);
      if (!sel) xm[addr] = sx10(val);
      else      wm[addr] = sx10(val);
      tick();
      hif.wr_en = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         xm[i] = 0;
         wm[i] = 0;
      end
   endtask

   // One full pass with exact cycle-by-cycle checks relative to the start edge.
   // inject_at >= 0 pulses start plus a write of w[0]=99 while streaming.
   task automatic run_pass(input string name, input int inject_at, input bit wr_now,
                           input bit wsel, input int waddr, input int wdata);
      longint exp_acc;
      if (wr_now) begin
         hif.wr_en   = 1'b1;
         hif.wr_sel  = wsel;
         hif.wr_addr = 3'(waddr);
         hif.wr_data = 10'(wdata);
         if (!wsel) xm[waddr] = sx10(wdata);
         else       wm[waddr] = sx10(wdata);
      end
      exp_acc = BIAS;
      for (int i = 0; i < N; i++) exp_acc += longint'(xm[i]) * longint'(wm[i]);
      hif.start = 1'b1;
      tick();
      hif.start = 1'b0;
      hif.wr_en = 1'b0;
      check({name, "_clr_accrst"}, acc_rst, 1);
      check({name, "_clr_busy"}, hif.busy, 1);
      check({name, "_clr_din"}, din, 0);
      for (int k = 0; k < N; k++) begin
         if (k == inject_at) begin
            hif.start   = 1'b1;
            hif.wr_en   = 1'b1;
            hif.wr_sel  = 1'b1;
            hif.wr_addr = 3'd0;
            hif.wr_data = 10'd99;
         end
         tick();
         hif.start = 1'b0;
         hif.wr_en = 1'b0;
         check($sformatf("%s_din%0d", name, k), din, longint'(xm[k]) * longint'(wm[k]));
         check($sformatf("%s_vld%0d", name, k), din_valid, 1);
         check($sformatf("%s_nodone%0d", name, k), hif.done, 0);
         check($sformatf("%s_accrst%0d", name, k), acc_rst, 0);
      end
      tick();
      check({name, "_done"}, hif.done, 1);
      check({name, "_done_din"}, din, 0);
      check({name, "_done_vld"}, din_valid, 0);
      check({name, "_done_busy"}, hif.busy, 1);
      tick();
      check({name, "_after_done"}, hif.done, 0);
      check({name, "_after_busy"}, hif.busy, 0);
      check({name, "_acc"}, dout, exp_acc);
   endtask

   task automatic back_to_back();
      int     done_cyc [$];
      int     rst_cyc [$];
      bit     chk_acc;
      longint exp_acc;
      for (int i = 0; i < N; i++) begin
         mwrite(1'b0, i, int'($urandom_range(0, 1023)));
         mwrite(1'b1, i, int'($urandom_range(0, 1023)));
      end
      exp_acc = BIAS;
      for (int i = 0; i < N; i++) exp_acc += longint'(xm[i]) * longint'(wm[i]);
      chk_acc = 1'b0;
      hif.start = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (chk_acc) begin
            check("b2b_acc", dout, exp_acc);
            check("b2b_idle_busy", hif.busy, 0);
            chk_acc = 1'b0;
            if (done_cyc.size() == 3) break;
         end
         if (acc_rst) rst_cyc.push_back(c);
         if (hif.done) begin
            done_cyc.push_back(c);
            chk_acc = 1'b1;
            if (done_cyc.size() == 3) hif.start = 1'b0;
         end
      end
      hif.start = 1'b0;
      check("b2b_done_count", done_cyc.size(), 3);
      check("b2b_accrst_count", rst_cyc.size(), 3);
      for (int i = 1; i < done_cyc.size(); i++)
         check($sformatf("b2b_spacing%0d", i), done_cyc[i] - done_cyc[i-1], N + 3);
      for (int i = 0; i < done_cyc.size() && i < rst_cyc.size(); i++)
         check($sformatf("b2b_accrst_lead%0d", i), done_cyc[i] - rst_cyc[i], N + 1);
   endtask

   initial begin
      hif.wr_en   = 1'b0;
      hif.wr_sel  = 1'b0;
      hif.wr_addr = '0;
      hif.wr_data = '0;
      hif.start   = 1'b0;
      clear_model();

      rst = 1'b0;
      tick();
      tick();
      check("rst_din", din, 0);
      check("rst_vld", din_valid, 0);
      check("rst_accrst", acc_rst, 0);
      check("rst_done", hif.done, 0);
      check("rst_busy", hif.busy, 0);
      rst = 1'b1;
      tick();
      run_pass("zero", -1, 1'b0, 1'b0, 0, 0);

      begin
         int bx [N] = '{1, 2, 3, 4, -3, 2, -5, 10};
         for (int i = 0; i < N; i++) begin
            mwrite(1'b0, i, bx[i]);
            mwrite(1'b1, i, 1);
         end
      end
      run_pass("basic", -1, 1'b0, 1'b0, 0, 0);

      for (int i = 0; i < N; i++) begin
         mwrite(1'b0, i, 0);
         mwrite(1'b1, i, 0);
      end
      mwrite(1'b0, 0, -512);
      mwrite(1'b1, 0, -512);
      mwrite(1'b0, 1, -512);
      mwrite(1'b1, 1, 511);
      run_pass("extreme", -1, 1'b0, 1'b0, 0, 0);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < N; i++) begin
            mwrite(1'b0, i, int'($urandom_range(0, 1023)));
            mwrite(1'b1, i, int'($urandom_range(0, 1023)));
         end
         run_pass($sformatf("rand%0d", r), -1, 1'b0, 1'b0, 0, 0);
      end

      run_pass("busy_inj", 3, 1'b0, 1'b0, 0, 0);
      run_pass("busy_after", -1, 1'b0, 1'b0, 0, 0);

      for (int i = 0; i < N; i++) begin
         mwrite(1'b0, i, 0);
         mwrite(1'b1, i, 0);
      end
      mwrite(1'b1, 0, 3);
      run_pass("wr_start", -1, 1'b1, 1'b0, 0, 7);

      hif.start = 1'b1;
      tick();
      hif.start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      clear_model();
      check("midrst_din", din, 0);
      check("midrst_vld", din_valid, 0);
      check("midrst_accrst", acc_rst, 0);
      check("midrst_done", hif.done, 0);
      check("midrst_busy", hif.busy, 0);
      rst = 1'b1;
      for (int c = 0; c < N + 2; c++) begin
         tick();
         check($sformatf("midrst_nodone%0d", c), hif.done, 0);
      end
      run_pass("post_rst", -1, 1'b0, 1'b0, 0, 0);

      back_to_back();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
